// File: rtl/hud_score_timer.sv
// HUD game-status controller: BCD game clock and score driven by a four-state game FSM,
// plus a 3-cycle pixel pipeline that renders snapshot values through an external digit ROM.
module hud_score_timer #(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int TICKS_PER_SEC     = 25000000
) (
  input  logic                       clock_25,
  input  logic                       resetn,
  input  logic [PIXEL_DISPLAY_BIT:0] X,
  input  logic [PIXEL_DISPLAY_BIT:0] Y,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       point,
  input  logic                       game_over,
  input  logic                       digit_pixel,
  output logic [10:0]                digit_addr,
  output logic                       hud_pixel,
  output logic [15:0]                time_bcd,
  output logic [11:0]                score_bcd,
  output logic                       sec_tick,
  output logic                       running
);

  localparam int W  = PIXEL_DISPLAY_BIT + 1;
  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [15:0]   TIME_MAX   = 16'h9959;
  localparam logic [11:0]   SCORE_MAX  = 12'h999;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   time_q, time_d;
  logic [11:0]   score_q, score_d;
  logic          tick_q, tick_d;
  logic [15:0]   snap_time_q, snap_time_d;
  logic [11:0]   snap_score_q, snap_score_d;
  logic [10:0]   addr_q, addr_d;
  logic          vld_q, vld_d;
  logic          vld_d1_q;
  logic          hud_q, hud_d;
  logic          clear;

  function automatic logic [15:0] time_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd9) begin
      r[3:0] = t[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        r[7:4] = t[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          r[11:8] = t[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = t[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] score_inc(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    if (s[3:0] != 4'd9) begin
      r[3:0] = s[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (s[7:4] != 4'd9) begin
        r[7:4] = s[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = s[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    score_d = score_q;
    tick_d  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        // Counting happens in every RUN cycle, even the one that leaves RUN.
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (time_q != TIME_MAX) begin
            time_d = time_inc(time_q);
            tick_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (point && score_q != SCORE_MAX) score_d = score_inc(score_q);
        if (game_over)  state_d = OVER;
        else if (start) clear   = 1'b1;
        else if (pause) state_d = PAUSED;
      end
      PAUSED: begin
        if (game_over) begin
          state_d = OVER;
        end else if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      OVER: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      presc_d = '0;
      time_d  = '0;
      score_d = '0;
      tick_d  = 1'b0;
    end
  end

  logic       in_band, in_time, in_score;
  logic [5:0] t_off;
  logic [4:0] s_off;
  logic [3:0] row;
  logic [3:0] glyph;

  always_comb begin
    snap_time_d  = snap_time_q;
    snap_score_d = snap_score_q;
    if (X == '0 && Y == '0) begin
      snap_time_d  = time_q;
      snap_score_d = score_q;
    end

    t_off    = 6'(X - W'(174));
    s_off    = 5'(X - W'(444));
    row      = 4'(Y - W'(460));
    in_band  = (Y >= W'(460)) && (Y <= W'(475));
    in_time  = in_band && (X >= W'(174)) && (X <= W'(213));
    in_score = in_band && (X >= W'(444)) && (X <= W'(467));

    glyph = 4'd0;
    if (in_time) begin
      case (t_off[5:3])
        3'd0:    glyph = snap_time_q[15:12];
        3'd1:    glyph = snap_time_q[11:8];
        3'd2:    glyph = 4'd10;
        3'd3:    glyph = snap_time_q[7:4];
        default: glyph = snap_time_q[3:0];
      endcase
    end else if (in_score) begin
      case (s_off[4:3])
        2'd0:    glyph = snap_score_q[11:8];
        2'd1:    glyph = snap_score_q[7:4];
        default: glyph = snap_score_q[3:0];
      endcase
    end

    vld_d  = in_time || in_score;
    addr_d = 11'd0;
    if (in_time)       addr_d = {glyph, row, t_off[2:0]};
    else if (in_score) addr_d = {glyph, row, s_off[2:0]};

    hud_d = digit_pixel & vld_d1_q;
  end

  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      time_q       <= '0;
      score_q      <= '0;
      tick_q       <= 1'b0;
      snap_time_q  <= '0;
      snap_score_q <= '0;
      addr_q       <= '0;
      vld_q        <= 1'b0;
      vld_d1_q     <= 1'b0;
      hud_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      time_q       <= time_d;
      score_q      <= score_d;
      tick_q       <= tick_d;
      snap_time_q  <= snap_time_d;
      snap_score_q <= snap_score_d;
      addr_q       <= addr_d;
      vld_q        <= vld_d;
      vld_d1_q     <= vld_q;
      hud_q        <= hud_d;
    end
  end

  assign digit_addr = addr_q;
  assign hud_pixel  = hud_q;
  assign time_bcd   = time_q;
  assign score_bcd  = score_q;
  assign sec_tick   = tick_q;
  assign running    = (state_q == RUN);

endmodule

// File: tb/tb_hud_score_timer.sv
// Directed bench for hud_score_timer with a 4-cycle game second and a behavioural digit ROM.
module tb_hud_score_timer;

  logic        clock_25 = 1'b0;
  logic        resetn;
  logic [9:0]  X, Y;
  logic        start, pause, point, game_over;
  logic        digit_pixel;
  logic [10:0] digit_addr;
  logic        hud_pixel;
  logic [15:0] time_bcd;
  logic [11:0] score_bcd;
  logic        sec_tick;
  logic        running;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;

  hud_score_timer #(.PIXEL_DISPLAY_BIT(9), .TICKS_PER_SEC(4)) dut (
    .clock_25(clock_25), .resetn(resetn), .X(X), .Y(Y),
    .start(start), .pause(pause), .point(point), .game_over(game_over),
    .digit_pixel(digit_pixel), .digit_addr(digit_addr), .hud_pixel(hud_pixel),
    .time_bcd(time_bcd), .score_bcd(score_bcd), .sec_tick(sec_tick), .running(running)
  );

  always #5 clock_25 = ~clock_25;

  function automatic logic rom_bit(input logic [10:0] a);
    return ~(^a);
  endfunction

  always @(posedge clock_25) digit_pixel <= rom_bit(digit_addr);

  task automatic step();
    @(posedge clock_25);
    #1;
    if (sec_tick) tick_cnt++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [10:0] addr;
  } vec_t;

  vec_t vecs[12];
  int   glyphs[5];
  logic eh[43];

  initial begin
    logic [10:0] ea;
    logic        ev;
    int          xi;

    vecs[0]  = '{10'd174, 10'd460, 11'h080};
    vecs[1]  = '{10'd181, 10'd460, 11'h087};
    vecs[2]  = '{10'd182, 10'd463, 11'h118};
    vecs[3]  = '{10'd190, 10'd475, 11'h578};
    vecs[4]  = '{10'd213, 10'd460, 11'h207};
    vecs[5]  = '{10'd214, 10'd460, 11'h000};
    vecs[6]  = '{10'd173, 10'd460, 11'h000};
    vecs[7]  = '{10'd174, 10'd459, 11'h000};
    vecs[8]  = '{10'd174, 10'd476, 11'h000};
    vecs[9]  = '{10'd444, 10'd461, 11'h008};
    vecs[10] = '{10'd467, 10'd470, 11'h057};
    vecs[11] = '{10'd468, 10'd460, 11'h000};
    glyphs = '{1, 2, 10, 3, 4};

    resetn = 1'b0; start = 0; pause = 0; point = 0; game_over = 0;
    X = 10'd300; Y = 10'd0;
    #23;
    chk("rst_time", time_bcd, 0);
    chk("rst_score", score_bcd, 0);
    chk("rst_run", running, 0);
    chk("rst_tick", sec_tick, 0);
    chk("rst_addr", digit_addr, 0);
    chk("rst_hud", hud_pixel, 0);
    @(negedge clock_25) resetn = 1'b1;
    steps(3);
    chk("idle_run", running, 0);

    // 240 RUN cycles make exactly one minute
    start = 1; step(); start = 0;
    chk("start_run", running, 1);
    tick_cnt = 0;
    steps(240);
    chk("min_ticks", tick_cnt, 60);
    chk("min_time", time_bcd, 16'h0100);
    chk("min_score", score_bcd, 0);

    // advance to 12:34, pause and take the render snapshot
    steps(2776);
    chk("t1234", time_bcd, 16'h1234);
    pause = 1; step();
    chk("paused_run", running, 0);
    X = 10'd0; Y = 10'd0; step();
    for (int i = 0; i < 12; i++) begin
      X = vecs[i].x; Y = vecs[i].y;
      step();
      chk($sformatf("vec%0d_addr", i), digit_addr, vecs[i].addr);
    end
    Y = 10'd460;
    for (int i = 0; i < 43; i++) begin
      xi = 174 + i;
      X = 10'(xi);
      step();
      ev = (xi <= 213);
      ea = ev ? {4'(glyphs[i / 8]), 4'd0, 3'(i % 8)} : 11'd0;
      chk($sformatf("scan_addr_x%0d", xi), digit_addr, ea);
      eh[i] = ev & rom_bit(ea);
      if (i >= 2) chk($sformatf("scan_hud_x%0d", xi - 2), hud_pixel, eh[i - 2]);
    end
    X = 10'd300; Y = 10'd0;
    chk("pause_frozen", time_bcd, 16'h1234);

    // release and run into saturation
    pause = 0; step();
    steps(20975);
    chk("t9958", time_bcd, 16'h9958);
    tick_cnt = 0;
    steps(12);
    chk("sat_time", time_bcd, 16'h9959);
    chk("sat_ticks", tick_cnt, 1);

    // restart in RUN, then score carry and saturation
    start = 1; step(); start = 0;
    chk("restart_time", time_bcd, 0);
    chk("restart_score", score_bcd, 0);
    point = 1;
    steps(99);
    chk("score099", score_bcd, 12'h099);
    step();
    chk("score100", score_bcd, 12'h100);
    steps(900);
    chk("score_sat", score_bcd, 12'h999);
    point = 0;

    // pause with prescaler held at 2
    start = 1; step(); start = 0;
    step();
    pause = 1; step();
    point = 1; tick_cnt = 0;
    steps(10);
    point = 0;
    chk("pz_time", time_bcd, 0);
    chk("pz_score", score_bcd, 0);
    chk("pz_ticks", tick_cnt, 0);
    pause = 0; step();
    chk("pz_release_run", running, 1);
    step();
    chk("pz_tick_early", sec_tick, 0);
    step();
    chk("pz_tick_due", sec_tick, 1);
    chk("pz_time1", time_bcd, 16'h0001);

    // point and game_over together
    start = 1; step(); start = 0;
    point = 1; steps(5);
    chk("score005", score_bcd, 12'h005);
    game_over = 1; step(); point = 0; game_over = 0;
    chk("go_score", score_bcd, 12'h006);
    chk("go_run", running, 0);
    steps(8);
    chk("over_time", time_bcd, 16'h0001);
    chk("over_score", score_bcd, 12'h006);
    start = 1; step(); start = 0;
    chk("ng_time", time_bcd, 0);
    chk("ng_score", score_bcd, 0);
    chk("ng_run", running, 1);

    // asynchronous reset mid-game
    point = 1; steps(3); point = 0;
    chk("pre_rst_score", score_bcd, 12'h003);
    resetn = 1'b0; #1;
    chk("arst_score", score_bcd, 0);
    chk("arst_run", running, 0);
    @(negedge clock_25) resetn = 1'b1;
    steps(5);
    chk("post_rst_run", running, 0);
    chk("post_rst_time", time_bcd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
